rps_scoreboard: RTL and testbench

RPS_SCOREBOARD -- requirements
Module: rps_scoreboard

---
 rtl/rps_scoreboard.sv | 105 ++++++++++
 tb/tb_rps_scoreboard.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rps_scoreboard.sv
// Rock-paper-scissors match scoreboard: accumulates per-player round wins, counts draws,
// and latches the champion(s) when any score reaches TARGET; one-cycle update latency.
module rps_scoreboard #(
   parameter int N_PLAYERS = 3,
   parameter int SCORE_W   = 4,
   parameter int TARGET    = 3,
   parameter int CNT_W     = 6
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          new_match,
   input  logic                          round_valid,
   input  logic [N_PLAYERS-1:0]          winner_mask,
   output logic [N_PLAYERS*SCORE_W-1:0]  scores,
   output logic [CNT_W-1:0]              round_count,
   output logic [CNT_W-1:0]              draw_count,
   output logic [CNT_W-1:0]              cycle_count,
   output logic                          result_valid,
   output logic [N_PLAYERS-1:0]          last_mask,
   output logic                          match_done,
   output logic [N_PLAYERS-1:0]          champion_mask
);

   typedef enum logic {PLAY = 1'b0, DONE = 1'b1} state_t;

   localparam logic [SCORE_W-1:0]   SCORE_MAX = '1;
   localparam logic [SCORE_W-1:0]   SCORE_ONE = SCORE_W'(1);
   localparam logic [SCORE_W-1:0]   TARGET_S  = SCORE_W'(TARGET);
   localparam logic [CNT_W-1:0]     CNT_MAX   = '1;
   localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
   localparam logic [N_PLAYERS-1:0] DRAW_MASK = '1;

   state_t                         state, state_nxt;
   logic [N_PLAYERS*SCORE_W-1:0]   scores_nxt;
   logic [CNT_W-1:0]               round_nxt, draw_nxt, cycle_nxt;
   logic                           valid_nxt;
   logic [N_PLAYERS-1:0]           last_nxt, champ_nxt, at_target;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= PLAY;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      scores_nxt = scores;
      round_nxt = round_count;
      draw_nxt = draw_count;
      cycle_nxt = cycle_count + CNT_ONE;
      valid_nxt = 1'b0;
      last_nxt = last_mask;
      champ_nxt = champion_mask;
      at_target = '0;
      if (new_match) begin
         state_nxt = PLAY;
         scores_nxt = '0;
         round_nxt = '0;
         draw_nxt = '0;
         cycle_nxt = '0;
         last_nxt = '0;
         champ_nxt = '0;
      end else if (state == PLAY && round_valid && winner_mask != '0) begin
         valid_nxt = 1'b1;
         last_nxt = winner_mask;
         if (round_count != CNT_MAX) round_nxt = round_count + CNT_ONE;
         if (winner_mask == DRAW_MASK) begin
            if (draw_count != CNT_MAX) draw_nxt = draw_count + CNT_ONE;
         end else begin
            // Champion detection looks at the post-increment scores so the match ends on this edge.
            for (int i = 0; i < N_PLAYERS; i++) begin
               if (winner_mask[i] && scores[i*SCORE_W +: SCORE_W] != SCORE_MAX)
                  scores_nxt[i*SCORE_W +: SCORE_W] = scores[i*SCORE_W +: SCORE_W] + SCORE_ONE;
               at_target[i] = (scores_nxt[i*SCORE_W +: SCORE_W] == TARGET_S);
            end
            if (at_target != '0) begin
               state_nxt = DONE;
               champ_nxt = at_target;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         scores        <= '0;
         round_count   <= '0;
         draw_count    <= '0;
         cycle_count   <= '0;
         result_valid  <= 1'b0;
         last_mask     <= '0;
         champion_mask <= '0;
      end else begin
         scores        <= scores_nxt;
         round_count   <= round_nxt;
         draw_count    <= draw_nxt;
         cycle_count   <= cycle_nxt;
         result_valid  <= valid_nxt;
         last_mask     <= last_nxt;
         champion_mask <= champ_nxt;
      end
   end

   assign match_done = (state == DONE);

endmodule

// File: tb/tb_rps_scoreboard.sv
// Directed bench for rps_scoreboard: default instance plus a narrow-counter instance.
module tb_rps_scoreboard;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;

   logic        new_match = 1'b0, round_valid = 1'b0;
   logic [2:0]  winner_mask = '0;
   logic [11:0] scores;
   logic [5:0]  round_count, draw_count, cycle_count;
   logic        result_valid, match_done;
   logic [2:0]  last_mask, champion_mask;

   logic        nm2 = 1'b0, rv2 = 1'b0;
   logic [2:0]  wm2 = '0;
   logic [5:0]  sc2;
   logic [1:0]  rc2, dc2, cc2;
   logic        vld2, done2;
   logic [2:0]  last2, champ2;

   int checks = 0;
   int passed = 0;

   rps_scoreboard dut (
      .CLK(CLK), .RST(RST), .new_match(new_match), .round_valid(round_valid),
      .winner_mask(winner_mask), .scores(scores), .round_count(round_count),
      .draw_count(draw_count), .cycle_count(cycle_count), .result_valid(result_valid),
      .last_mask(last_mask), .match_done(match_done), .champion_mask(champion_mask)
   );

   rps_scoreboard #(.N_PLAYERS(3), .SCORE_W(2), .TARGET(3), .CNT_W(2)) dut2 (
      .CLK(CLK), .RST(RST), .new_match(nm2), .round_valid(rv2),
      .winner_mask(wm2), .scores(sc2), .round_count(rc2),
      .draw_count(dc2), .cycle_count(cc2), .result_valid(vld2),
      .last_mask(last2), .match_done(done2), .champion_mask(champ2)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else passed++;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // reset state, no clock edge seen yet
      #2;
      chk("rst_scores", scores, 0);
      chk("rst_done", match_done, 0);
      chk("rst_cycle", cycle_count, 0);
      chk("rst_champ", champion_mask, 0);
      #10 RST = 1'b0;
      tick();
      chk("first_edge_cycle", cycle_count, 1);
      chk("first_edge_round", round_count, 0);

      // player A wins three straight rounds
      round_valid = 1'b1; winner_mask = 3'b100;
      tick();
      chk("a1_scores", scores, 12'h100);
      chk("a1_valid", result_valid, 1);
      chk("a1_done", match_done, 0);
      tick();
      chk("a2_scores", scores, 12'h200);
      tick();
      chk("a3_scores", scores, 12'h300);
      chk("a3_done", match_done, 1);
      chk("a3_champ", champion_mask, 3'b100);
      chk("a3_round", round_count, 3);
      chk("a3_cycle", cycle_count, 4);

      // rounds ignored in DONE
      winner_mask = 3'b001;
      tick();
      chk("done_scores", scores, 12'h300);
      chk("done_valid", result_valid, 0);
      chk("done_round", round_count, 3);
      chk("done_last", last_mask, 3'b100);
      chk("done_cycle", cycle_count, 5);

      // new_match wins over a simultaneous round
      new_match = 1'b1;
      tick();
      chk("nm_scores", scores, 0);
      chk("nm_done", match_done, 0);
      chk("nm_valid", result_valid, 0);
      chk("nm_round", round_count, 0);
      chk("nm_cycle", cycle_count, 0);
      chk("nm_last", last_mask, 0);
      chk("nm_champ", champion_mask, 0);
      new_match = 1'b0; round_valid = 1'b0;
      tick();
      chk("nm_cycle_run", cycle_count, 1);

      // draw, then an undecided round
      round_valid = 1'b1; winner_mask = 3'b111;
      tick();
      chk("draw_draws", draw_count, 1);
      chk("draw_round", round_count, 1);
      chk("draw_valid", result_valid, 1);
      chk("draw_scores", scores, 0);
      winner_mask = 3'b000;
      tick();
      chk("zero_valid", result_valid, 0);
      chk("zero_round", round_count, 1);
      chk("zero_last", last_mask, 3'b111);

      // A and B climb together and tie at the target
      winner_mask = 3'b110;
      tick();
      chk("ab1_scores", scores, 12'h110);
      tick();
      chk("ab2_scores", scores, 12'h220);
      winner_mask = 3'b001;
      tick();
      chk("c1_scores", scores, 12'h221);
      winner_mask = 3'b110;
      tick();
      chk("tie_scores", scores, 12'h331);
      chk("tie_done", match_done, 1);
      chk("tie_champ", champion_mask, 3'b110);
      chk("tie_round", round_count, 5);
      chk("tie_draws", draw_count, 1);

      // asynchronous reset mid-match
      round_valid = 1'b0; new_match = 1'b1;
      tick();
      new_match = 1'b0; round_valid = 1'b1; winner_mask = 3'b010;
      tick();
      chk("pre_rst_scores", scores, 12'h010);
      round_valid = 1'b0;
      #3 RST = 1'b1;
      #1;
      chk("arst_scores", scores, 0);
      chk("arst_round", round_count, 0);
      chk("arst_cycle", cycle_count, 0);
      chk("arst_valid", result_valid, 0);
      chk("arst_last", last_mask, 0);
      #2 RST = 1'b0;
      tick();
      chk("post_rst_cycle", cycle_count, 1);
      chk("post_rst_scores", scores, 0);

      // narrow counters saturate, cycle counter wraps
      nm2 = 1'b1;
      tick();
      chk("n2_cycle0", cc2, 0);
      nm2 = 1'b0; rv2 = 1'b1; wm2 = 3'b111;
      tick(); tick(); tick();
      chk("n2_draw3", dc2, 3);
      chk("n2_cycle3", cc2, 3);
      tick();
      chk("n2_cycle_wrap", cc2, 0);
      chk("n2_draw_sat", dc2, 3);
      tick();
      chk("n2_draw_sat5", dc2, 3);
      chk("n2_round_sat5", rc2, 3);
      chk("n2_scores", sc2, 0);
      chk("n2_done", done2, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
